// File: rtl/clk_div_pkg.sv
// ============================================================================
// clk_div_pkg : shared state encoding and defaults for the clock-divider bank
// Rev 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  localparam int DEF_DIV_W       = 8;
  localparam int DEF_LOCK_CYCLES = 16;
  localparam int DEF_DIV         = 2;
  localparam int DEF_PHASE       = 0;

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
// ============================================================================
// clk_div_chan : one divider channel - wrap counter plus registered CE/CLK decode
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_div_chan #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             clk_out,
  output logic             ce_out
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] count_nxt;
  logic [DIV_W-1:0] term;
  logic [DIV_W-1:0] half;
  logic             active;

  assign term = div - DIV_W'(1);
  assign half = div >> 1;

  // Outputs are decoded from the value the counter is about to hold, so they
  // line up with the count and are zero whenever the channel is not counting.
  always_comb begin
    count_nxt = count;
    active    = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = phase;
      active    = 1'b1;
    end else if (run) begin
      count_nxt = (count == term) ? '0 : count + DIV_W'(1);
      active    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      ce_out  <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      count   <= count_nxt;
      ce_out  <= active && (count_nxt == term);
      clk_out <= active && (count_nxt < half);
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_div_bank.sv
// ============================================================================
// clk_div_bank : NUM_CH phase-aligned programmable dividers with lock/error flags
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                    CLK_IN1,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic                    CFG_LOAD,
  input  logic [NUM_CH*DIV_W-1:0] DIV_CFG,
  input  logic [NUM_CH*DIV_W-1:0] PHASE_CFG,
  output logic [NUM_CH-1:0]       CLK_OUT,
  output logic [NUM_CH-1:0]       CE_OUT,
  output logic                    LOCKED,
  output logic                    CFG_ERR
);

  localparam int              SET_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

  state_t                    state;
  logic [NUM_CH*DIV_W-1:0]   div_sh;
  logic [NUM_CH*DIV_W-1:0]   phase_sh;
  logic [SET_W-1:0]          settle_cnt;
  logic                      cfg_bad;
  logic                      shadow_bad;
  logic                      chan_clr;
  logic                      chan_load;
  logic                      chan_run;

  function automatic logic cfg_invalid(input logic [NUM_CH*DIV_W-1:0] d,
                                       input logic [NUM_CH*DIV_W-1:0] p);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (d[i*DIV_W +: DIV_W] == '0 || p[i*DIV_W +: DIV_W] >= d[i*DIV_W +: DIV_W])
        bad = 1'b1;
    end
    return bad;
  endfunction

  assign cfg_bad    = cfg_invalid(DIV_CFG, PHASE_CFG);
  assign shadow_bad = cfg_invalid(div_sh, phase_sh);

  // A load strobe pre-empts counting for one edge so no channel sees a mixed config.
  assign chan_clr  = !EN;
  assign chan_load = EN && !CFG_LOAD && (state == ST_ALIGN);
  assign chan_run  = EN && !CFG_LOAD && ((state == ST_SETTLE) || (state == ST_RUN));

  always_ff @(posedge CLK_IN1 or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      div_sh     <= {NUM_CH{DIV_W'(DEF_DIV)}};
      phase_sh   <= {NUM_CH{DIV_W'(DEF_PHASE)}};
      settle_cnt <= '0;
      LOCKED     <= 1'b0;
      CFG_ERR    <= 1'b0;
    end else if (!EN) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      LOCKED     <= 1'b0;
      CFG_ERR    <= 1'b0;
    end else if (CFG_LOAD) begin
      div_sh   <= DIV_CFG;
      phase_sh <= PHASE_CFG;
      LOCKED   <= 1'b0;
      CFG_ERR  <= cfg_bad;
      state    <= cfg_bad ? ST_ERR : ST_ALIGN;
    end else begin
      case (state)
        // The shadow may still hold a rejected config after an EN drop.
        ST_IDLE: begin
          CFG_ERR <= shadow_bad;
          state   <= shadow_bad ? ST_ERR : ST_ALIGN;
        end
        ST_ALIGN: begin
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            state  <= ST_RUN;
            LOCKED <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        ST_RUN:  LOCKED <= 1'b1;
        default: state <= ST_ERR;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_div_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk     (CLK_IN1),
      .rst_n   (RST_N),
      .clr     (chan_clr),
      .load    (chan_load),
      .run     (chan_run),
      .div     (div_sh[i*DIV_W +: DIV_W]),
      .phase   (phase_sh[i*DIV_W +: DIV_W]),
      .clk_out (CLK_OUT[i]),
      .ce_out  (CE_OUT[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
// ============================================================================
// tb_clk_div_bank : scoreboard bench for clk_div_bank (4 channels, 8-bit fields)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_bank;

  localparam int NCH  = 4;
  localparam int W    = 8;
  localparam int LOCK = 16;

  localparam int S_IDLE = 0, S_ALIGN = 1, S_SETTLE = 2, S_RUN = 3, S_ERR = 4;

  logic             CLK_IN1;
  logic             RST_N;
  logic             EN;
  logic             CFG_LOAD;
  logic [NCH*W-1:0] DIV_CFG;
  logic [NCH*W-1:0] PHASE_CFG;
  logic [NCH-1:0]   CLK_OUT;
  logic [NCH-1:0]   CE_OUT;
  logic             LOCKED;
  logic             CFG_ERR;

  clk_div_bank #(
    .NUM_CH      (NCH),
    .DIV_W       (W),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .CLK_IN1   (CLK_IN1),
    .RST_N     (RST_N),
    .EN        (EN),
    .CFG_LOAD  (CFG_LOAD),
    .DIV_CFG   (DIV_CFG),
    .PHASE_CFG (PHASE_CFG),
    .CLK_OUT   (CLK_OUT),
    .CE_OUT    (CE_OUT),
    .LOCKED    (LOCKED),
    .CFG_ERR   (CFG_ERR)
  );

  initial CLK_IN1 = 1'b0;
  always #5 CLK_IN1 = ~CLK_IN1;

  typedef struct {
    logic [NCH-1:0] clk_o;
    logic [NCH-1:0] ce_o;
    logic           lock;
    logic           err;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int             m_state;
  int             m_div[NCH];
  int             m_ph[NCH];
  int             m_cnt[NCH];
  int             m_settle;
  logic [NCH-1:0] m_clk;
  logic [NCH-1:0] m_ce;
  logic           m_lock;
  logic           m_err;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = S_IDLE;
    m_settle = 0;
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = 2;
      m_ph[i]  = 0;
      m_cnt[i] = 0;
    end
    m_clk  = '0;
    m_ce   = '0;
    m_lock = 1'b0;
    m_err  = 1'b0;
  endtask

  function automatic logic model_bad();
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (m_div[i] == 0 || m_ph[i] >= m_div[i]) bad = 1'b1;
    return bad;
  endfunction

  task automatic model_decode();
    for (int i = 0; i < NCH; i++) begin
      m_ce[i]  = (m_cnt[i] == m_div[i] - 1);
      m_clk[i] = (m_cnt[i] < m_div[i] / 2);
    end
  endtask

  // Advances the model by one rising edge using the inputs about to be sampled.
  task automatic model_step();
    logic bad;
    m_clk = '0;
    m_ce  = '0;
    if (!EN) begin
      m_state = S_IDLE;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      m_lock = 1'b0;
      m_err  = 1'b0;
    end else if (CFG_LOAD) begin
      for (int i = 0; i < NCH; i++) begin
        m_div[i] = int'(DIV_CFG[i*W +: W]);
        m_ph[i]  = int'(PHASE_CFG[i*W +: W]);
      end
      bad     = model_bad();
      m_state = bad ? S_ERR : S_ALIGN;
      m_err   = bad;
      m_lock  = 1'b0;
    end else begin
      case (m_state)
        S_IDLE: begin
          bad     = model_bad();
          m_state = bad ? S_ERR : S_ALIGN;
          m_err   = bad;
        end
        S_ALIGN: begin
          for (int i = 0; i < NCH; i++) m_cnt[i] = m_ph[i];
          m_settle = 0;
          m_state  = S_SETTLE;
          model_decode();
        end
        S_SETTLE, S_RUN: begin
          for (int i = 0; i < NCH; i++) m_cnt[i] = (m_cnt[i] + 1) % m_div[i];
          model_decode();
          if (m_state == S_SETTLE) begin
            m_settle++;
            if (m_settle == LOCK) begin
              m_state = S_RUN;
              m_lock  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    e.clk_o = m_clk;
    e.ce_o  = m_ce;
    e.lock  = m_lock;
    e.err   = m_err;
    sb.push_back(e);
    @(posedge CLK_IN1);
    #1;
    e = sb.pop_front();
    chk("clk_out", int'(CLK_OUT), int'(e.clk_o));
    chk("ce_out",  int'(CE_OUT),  int'(e.ce_o));
    chk("locked",  int'(LOCKED),  int'(e.lock));
    chk("cfg_err", int'(CFG_ERR), int'(e.err));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg(input int d0, input int d1, input int d2, input int d3,
                         input int p0, input int p1, input int p2, input int p3);
    DIV_CFG   = {W'(d3), W'(d2), W'(d1), W'(d0)};
    PHASE_CFG = {W'(p3), W'(p2), W'(p1), W'(p0)};
  endtask

  task automatic load_cfg(input int d0, input int d1, input int d2, input int d3,
                          input int p0, input int p1, input int p2, input int p3);
    set_cfg(d0, d1, d2, d3, p0, p1, p2, p3);
    CFG_LOAD = 1'b1;
    tick();
    CFG_LOAD = 1'b0;
  endtask

  initial begin
    int n;
    int d[NCH];
    int p[NCH];

    RST_N    = 1'b0;
    EN       = 1'b0;
    CFG_LOAD = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #23;
    chk("rst_clk",  int'(CLK_OUT), 0);
    chk("rst_ce",   int'(CE_OUT),  0);
    chk("rst_lock", int'(LOCKED),  0);
    chk("rst_err",  int'(CFG_ERR), 0);
    RST_N = 1'b1;
    ticks(2);

    // 1: default divide-by-2 from reset shadow, lock latency
    EN = 1'b1;
    tick();
    n = 0;
    while (!LOCKED && n < 40) begin
      tick();
      n++;
    end
    chk("lock_latency", n, 17);
    ticks(6);

    // 2: mixed ratios and phases
    load_cfg(4, 3, 1, 8, 0, 2, 0, 5);
    ticks(40);

    // 3: reload in RUN drops lock next edge
    load_cfg(10, 3, 1, 8, 0, 2, 0, 5);
    chk("reload_lock_drop", int'(LOCKED), 0);
    ticks(30);

    // 4: invalid configs, then recovery
    load_cfg(4, 0, 1, 8, 0, 0, 0, 5);
    chk("err_flag_d0", int'(CFG_ERR), 1);
    ticks(4);
    load_cfg(4, 3, 1, 8, 0, 3, 0, 5);
    chk("err_flag_pd", int'(CFG_ERR), 1);
    chk("err_clk_zero", int'(CLK_OUT), 0);
    ticks(4);
    load_cfg(5, 3, 2, 7, 1, 0, 1, 6);
    chk("err_cleared", int'(CFG_ERR), 0);
    ticks(25);
    chk("relock", int'(LOCKED), 1);

    // 5: EN drop wins over a simultaneous load mid-SETTLE
    load_cfg(6, 2, 3, 4, 2, 1, 0, 3);
    ticks(5);
    set_cfg(9, 9, 9, 9, 8, 8, 8, 8);
    EN       = 1'b0;
    CFG_LOAD = 1'b1;
    tick();
    CFG_LOAD = 1'b0;
    chk("en_drop_clk", int'(CLK_OUT), 0);
    ticks(2);
    EN = 1'b1;
    ticks(30);

    // 6: asynchronous reset between edges
    #3;
    RST_N = 1'b0;
    #1;
    chk("async_clk",  int'(CLK_OUT), 0);
    chk("async_ce",   int'(CE_OUT),  0);
    chk("async_lock", int'(LOCKED),  0);
    model_reset();
    sb.delete();
    #2;
    RST_N = 1'b1;
    ticks(25);

    // Random valid configurations
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NCH; i++) begin
        d[i] = int'($urandom_range(1, 12));
        p[i] = int'($urandom_range(0, d[i] - 1));
      end
      load_cfg(d[0], d[1], d[2], d[3], p[0], p[1], p[2], p[3]);
      ticks(30);
    end

    // Largest ratio wraps through the full counter range
    load_cfg(255, 2, 1, 3, 250, 1, 0, 2);
    ticks(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
